// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer for a simple dual-port RAM.
// Keeps reads prefetched into a 2-entry head/skid stage to hide read latency.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_o
);

    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_used;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [1:0]            r_stage_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_en;
    logic [2:0]            w_occ;
    logic [1:0]            w_cnt_pop;
    logic [1:0]            w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_skid_nxt;

    assign s_ready = (r_ram_used < FULL) & ~clr;
    assign m_valid = (r_stage_cnt != 2'd0);
    assign m_data  = r_head;

    assign w_push = s_valid & s_ready;
    assign w_pop  = m_valid & m_ready;

    // Stage slots that will be taken once everything already issued lands
    assign w_occ   = {1'b0, r_stage_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rd_en = ~clr & (r_ram_used != '0) & (w_occ < 3'd2);

    assign ram_wr_en   = w_push;
    assign ram_wr_addr = r_wr_ptr;
    assign ram_data_i  = s_data;
    assign ram_rd_en   = w_rd_en;
    assign ram_rd_addr = r_rd_ptr;

    assign count = {1'b0, r_ram_used}
                 + (ADDR_WIDTH+2)'(r_inflight)
                 + (ADDR_WIDTH+2)'(r_stage_cnt);

    always_comb begin
        w_cnt_pop  = r_stage_cnt - {1'b0, w_pop};
        w_cnt_nxt  = w_cnt_pop;
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        if (w_pop) begin
            w_head_nxt = r_skid;
        end
        if (r_inflight) begin
            if (w_cnt_pop == 2'd0) begin
                w_head_nxt = ram_data_o;
            end else begin
                w_skid_nxt = ram_data_o;
            end
            w_cnt_nxt = w_cnt_pop + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_used  <= '0;
            r_inflight  <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
            r_stage_cnt <= 2'd0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_used  <= '0;
            r_inflight  <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
            r_stage_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_used  <= r_ram_used
                         + (ADDR_WIDTH+1)'(w_push)
                         - (ADDR_WIDTH+1)'(w_rd_en);
            r_inflight  <= w_rd_en;
            r_head      <= w_head_nxt;
            r_skid      <= w_skid_nxt;
            r_stage_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue scoreboard, directed
// and random stimulus on an 8-deep configuration.
module tb_ram_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 28;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_data_i;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_data_o;

    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;
    int outs     = 0;

    logic [DW-1:0] q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_data_i(ram_data_i),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_data_o(ram_data_o)
    );

    always #5 clk = ~clk;

    // Registered-read RAM, old data returned on address collision
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_data_i;
        if (ram_rd_en) ram_data_o <= mem[ram_rd_addr];
    end

    // Scoreboard monitor: words held must equal the model queue
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            n_checks++;
            if (count != q.size()) begin
                n_errors++;
                $display("FAIL count act=%0d exp=%0d t=%0t",
                         count, q.size(), $time);
            end
            if (prev_stall) begin
                n_checks++;
                if (!m_valid || m_data !== prev_data) begin
                    n_errors++;
                    $display("FAIL stall_hold act=%0b/%h exp=1/%h t=%0t",
                             m_valid, m_data, prev_data, $time);
                end
            end
            if (clr) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                if (m_valid && m_ready) begin
                    n_checks++;
                    outs++;
                    if (q.size() == 0) begin
                        n_errors++;
                        $display("FAIL pop_empty act=%h exp=none t=%0t",
                                 m_data, $time);
                    end else begin
                        exp_w = q.pop_front();
                        if (m_data !== exp_w) begin
                            n_errors++;
                            $display("FAIL data act=%h exp=%h t=%0t",
                                     m_data, exp_w, $time);
                        end
                    end
                end
                if (s_valid && s_ready) q.push_back(s_data);
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while ((count != 0 || m_valid) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n < budget), 64'd1);
    endtask

    initial begin
        int acc;
        int base;
        int gaps;
        int moved;
        int rdy_seen;
        int val;
        logic [AW+1:0] c0;

        rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_sready", s_ready, 1);
        chk("rst_mdata", m_data, 0);

        // single word latency
        s_valid = 1'b1; s_data = 28'h0ABCDEF; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lat_e0", m_valid, 0);
        step();
        chk("lat_e1", m_valid, 0);
        step();
        chk("lat_e2", m_valid, 1);
        chk("lat_data", m_data, 28'h0ABCDEF);
        step();
        chk("single_cnt", count, 0);
        chk("single_mv", m_valid, 0);

        // fill and backpressure
        m_ready = 1'b0; acc = 0;
        for (int i = 1; i <= 12; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            #1;
            if (s_ready) acc++;
            step();
        end
        s_valid = 1'b0;
        step(); step();
        chk("fill_acc", acc, 10);
        chk("fill_cnt", count, 10);
        chk("fill_sready", s_ready, 0);
        m_ready = 1'b1; base = outs; rdy_seen = 0;
        for (int i = 0; i < 30 && (outs - base) < 10; i++) begin
            step();
            if (s_ready) rdy_seen = 1;
        end
        chk("fill_drained", outs - base, 10);
        chk("fill_sready_back", rdy_seen, 1);
        wait_empty(20);

        // streaming across pointer wraps
        val = 100; gaps = 0; c0 = '0; moved = 0;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = DW'(val);
            #1;
            if (s_ready) val++;
            else gaps++;
            step();
            if (i >= 2 && !m_valid) gaps++;
            if (i == 5) c0 = count;
            if (i > 5 && count != c0) moved++;
        end
        chk("stream_gaps", gaps, 0);
        chk("stream_cnt", c0, 3);
        chk("stream_steady", moved, 0);
        s_valid = 1'b0;
        wait_empty(20);

        // random stall
        for (int i = 0; i < 2000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 99) < ((i < 1000) ? 70 : 35));
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        wait_empty(40);

        // flush with a read in flight
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = DW'(28'h100 + i);
            step();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("flush_pre_cnt", count, 4);
        chk("flush_inflight", dut.r_inflight, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_mv", m_valid, 0);
        step();
        chk("flush_mv2", m_valid, 0);
        s_valid = 1'b1; s_data = 28'h5;
        step();
        s_valid = 1'b0;
        acc = 0;
        while (!m_valid && acc < 10) begin
            step();
            acc++;
        end
        chk("flush_first", m_data, 28'h5);
        m_ready = 1'b1;
        wait_empty(10);

        // async reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = DW'(28'h200 + i);
            step();
        end
        s_valid = 1'b0;
        chk("pre_rst_cnt", count, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_mv", m_valid, 0);
        chk("arst_cnt", count, 0);
        chk("arst_rd", ram_rd_en, 0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_sready", s_ready, 1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
